// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Latency: n/a (package only).
// Backpressure: n/a. Build macro PS2_SCANCODE_DECODE_EN widens DATA_W to carry {brk,ext} tags.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

`ifdef PS2_SCANCODE_DECODE_EN
    localparam int DATA_W = 10;
`else
    localparam int DATA_W = 8;
`endif

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser followed by a glitch filter for one PS/2 line.
// Latency: 2 cycles sync + FILTER_LEN cycles of stable input before dout follows.
// Backpressure: none; free-running on every clk.
// Ports: clk, reset_n (async, active-low), din (asynchronous line), dout (filtered, resets to 1).
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(FILTER_LEN);

    logic [1:0]    sync_q, sync_d;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q,  cnt_d;

    // cnt_q counts consecutive samples that disagree with the filtered
    // value; the filtered value flips on the FILTER_LEN-th such sample.
    always_comb begin
        sync_d = {sync_q[0], din};
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: filter, deserialise, validate, buffer bytes in a FWFT FIFO.
// Latency: accepted byte visible on rd_valid/rd_data 2 cycles after the 11th detected ps2c fall (FIFO empty).
// Backpressure: rd_valid/rd_ready pop; when full a new byte is dropped with err_overflow (no PS/2 inhibit).
// Ports: clk, reset_n, ps2d/ps2c (async pins), rx_en; rd_data/rd_valid/rd_ready read side;
//        fifo_count, busy, err_parity/err_frame/err_timeout/err_overflow one-cycle pulses.
// Build macro PS2_SCANCODE_DECODE_EN: folds E0/F0 prefixes into {brk,ext} tags on the next byte.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 10000,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ps2d,
    input  logic              ps2c,
    input  logic              rx_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              busy,
    output logic              err_parity,
    output logic              err_frame,
    output logic              err_timeout,
    output logic              err_overflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    // ---------------- input conditioning ----------------
    logic ps2c_f, ps2d_f;
    logic ps2c_prev_q, ps2c_prev_d;
    logic fall;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (ps2c),
        .dout    (ps2c_f)
    );

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (ps2d),
        .dout    (ps2d_f)
    );

    assign ps2c_prev_d = ps2c_f;
    assign fall        = ps2c_prev_q & ~ps2c_f;

    // ---------------- frame FSM ----------------
    state_t                  state_q, state_d;
    logic [3:0]              bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic [WD_W-1:0]         wdog_q, wdog_d;
    logic                    err_par_q, err_par_d;
    logic                    err_frm_q, err_frm_d;
    logic                    err_to_q, err_to_d;
    logic                    accept;
    logic                    abort;

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        wdog_d    = wdog_q;
        err_par_d = 1'b0;
        err_frm_d = 1'b0;
        err_to_d  = 1'b0;
        accept    = 1'b0;
        abort     = 1'b0;

        unique case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (fall && rx_en) begin
                    if (!ps2d_f) begin
                        state_d    = SHIFT;
                        bit_idx_d  = 4'd1;
                        frame_d[0] = 1'b0;
                    end else begin
                        err_frm_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (!rx_en) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (fall) begin
                    frame_d[bit_idx_q] = ps2d_f;
                    bit_idx_d          = bit_idx_q + 4'd1;
                    wdog_d             = '0;
                    if (bit_idx_q == 4'(FRAME_BITS - 1)) begin
                        state_d = CHECK;
                    end
                end else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                    abort    = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            CHECK: begin
                state_d = IDLE;
                wdog_d  = '0;
                if (!rx_en) begin
                    abort = 1'b1;
                end else if (frame_q[0] || !frame_q[FRAME_BITS-1]) begin
                    err_frm_d = 1'b1;
                end else if (^frame_q[9:1] == 1'b0) begin
                    // odd parity over data+parity must be 1
                    err_par_d = 1'b1;
                end else begin
                    accept = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- byte formatting ----------------
    logic              push_req;
    logic [DATA_W-1:0] push_dat;

`ifdef PS2_SCANCODE_DECODE_EN
    logic ext_pend_q, ext_pend_d;
    logic brk_pend_q, brk_pend_d;

    always_comb begin
        push_req   = 1'b0;
        push_dat   = {brk_pend_q, ext_pend_q, frame_q[8:1]};
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        if (abort) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (accept) begin
            if (frame_q[8:1] == PFX_EXT) begin
                ext_pend_d = 1'b1;
            end else if (frame_q[8:1] == PFX_BRK) begin
                brk_pend_d = 1'b1;
            end else begin
                // flags are consumed even if the FIFO ends up dropping the byte
                push_req   = 1'b1;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
        end else begin
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
        end
    end
`else
    always_comb begin
        push_req = accept;
        push_dat = frame_q[8:1];
    end
`endif

    // ---------------- FWFT FIFO ----------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              err_ovf_q, err_ovf_d;
    logic              full, pop, push;

    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        pop       = rd_valid & rd_ready;
        // a same-cycle pop frees the slot, so a full FIFO still takes the byte
        push      = push_req & (~full | pop);
        err_ovf_d = push_req & full & ~pop;
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2c_prev_q <= 1'b1;
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            frame_q     <= '0;
            wdog_q      <= '0;
            err_par_q   <= 1'b0;
            err_frm_q   <= 1'b0;
            err_to_q    <= 1'b0;
            err_ovf_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            ps2c_prev_q <= ps2c_prev_d;
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            frame_q     <= frame_d;
            wdog_q      <= wdog_d;
            err_par_q   <= err_par_d;
            err_frm_q   <= err_frm_d;
            err_to_q    <= err_to_d;
            err_ovf_q   <= err_ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // ---------------- outputs ----------------
    assign rd_valid     = (count_q != '0);
    // gate so rd_data reads 0 after reset rather than stale RAM contents
    assign rd_data      = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count   = count_q;
    assign busy         = (state_q != IDLE);
    assign err_parity   = err_par_q;
    assign err_frame    = err_frm_q;
    assign err_timeout  = err_to_q;
    assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
`timescale 1ns/1ps
module tb_ps2_rx_fifo;
    import ps2_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              ps2d = 1'b1;
    logic              ps2c = 1'b1;
    logic              rx_en = 1'b0;
    logic              rd_ready = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [CNT_W-1:0]  fifo_count;
    logic              busy;
    logic              err_parity, err_frame, err_timeout, err_overflow;

    ps2_rx_fifo #(
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (10000),
        .DEPTH       (DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ps2d         (ps2d),
        .ps2c         (ps2c),
        .rx_en        (rx_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .fifo_count   (fifo_count),
        .busy         (busy),
        .err_parity   (err_parity),
        .err_frame    (err_frame),
        .err_timeout  (err_timeout),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad = 0;
    int n_par = 0, n_frm = 0, n_to = 0, n_ovf = 0;
    int to_cyc = 0;
    int last_fall = 0;
    int p0, f0, t0, o0, d;
    logic [DATA_W-1:0] sb_q [$];
    logic [DATA_W-1:0] exp_dat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: error pulse counting and scoreboard compare on every pop.
    always @(negedge clk) begin
        if (reset_n) begin
            if (err_parity)   n_par++;
            if (err_frame)    n_frm++;
            if (err_overflow) n_ovf++;
            if (err_timeout) begin
                n_to++;
                to_cyc = cyc;
            end
            if (rd_valid && rd_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got 0x%0h expected no entry", rd_data);
                end else begin
                    exp_dat = sb_q.pop_front();
                    check("pop_data", 32'(rd_data), 32'(exp_dat));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Device-driven bits, LSB first; ps2c half-period 50 clk = 500 ns.
    task automatic ps2_bits(input logic [10:0] bits, input int n);
        for (int k = 0; k < n; k++) begin
            tick(25);
            ps2d = bits[k];
            tick(25);
            ps2c = 1'b0;
            last_fall = cyc;
            tick(50);
            ps2c = 1'b1;
        end
        tick(25);
        ps2d = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        logic p;
        p = (~^b) ^ bad_par;
        return {stop, p, b, 1'b0};
    endfunction

    task automatic send(input logic [7:0] b, input logic bad_par, input logic stop);
        ps2_bits(mk_frame(b, bad_par, stop), 11);
        tick(10);
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        tick(DEPTH + 4);
        rd_ready = 1'b0;
        tick(2);
        check("drain_sb_empty", 32'(sb_q.size()), 0);
        check("drain_count", 32'(fifo_count), 0);
    endtask

    initial begin
        // ---- reset state ----
        tick(3);
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_data", 32'(rd_data), 0);
        check("rst_errs", 32'({err_parity, err_frame, err_timeout, err_overflow}), 0);
        reset_n = 1'b1;
        rx_en = 1'b1;
        tick(5);

        // ---- single good frame 0x1C ----
        sb_q.push_back(DATA_W'(8'h1C));
        send(8'h1C, 1'b0, 1'b1);
        check("t1_valid", 32'(rd_valid), 1);
        check("t1_count", 32'(fifo_count), 1);
        check("t1_head", 32'(rd_data), 32'h1C);
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        tick(2);
        check("t1_count_after_pop", 32'(fifo_count), 0);

        // ---- parity error, stop error, bad start ----
        p0 = n_par; f0 = n_frm;
        send(8'h1C, 1'b1, 1'b1);
        check("t2_par_pulse", 32'(n_par - p0), 1);
        check("t2_par_count", 32'(fifo_count), 0);
        send(8'h1C, 1'b0, 1'b0);
        check("t2_frm_pulse", 32'(n_frm - f0), 1);
        check("t2_frm_no_par", 32'(n_par - p0), 1);
        ps2_bits(11'h7FF, 1);
        tick(10);
        check("t2_bad_start", 32'(n_frm - f0), 2);
        check("t2_bad_start_idle", 32'(busy), 0);

        // ---- watchdog ----
        t0 = n_to; p0 = n_par; f0 = n_frm;
        ps2_bits(mk_frame(8'h1C, 1'b0, 1'b1), 5);
        check("t3_busy_mid", 32'(busy), 1);
        tick(12000);
        check("t3_to_pulse", 32'(n_to - t0), 1);
        d = to_cyc - last_fall;
        check("t3_to_window", 32'(d >= 10005 && d <= 10025), 1);
        check("t3_to_idle", 32'(busy), 0);
        check("t3_to_other_errs", 32'((n_par - p0) + (n_frm - f0)), 0);
        check("t3_to_count", 32'(fifo_count), 0);
        sb_q.push_back(DATA_W'(8'h2A));
        send(8'h2A, 1'b0, 1'b1);
        check("t3_after_count", 32'(fifo_count), 1);
        drain();

        // ---- fill + overflow ----
        o0 = n_ovf;
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i < DEPTH) sb_q.push_back(DATA_W'(8'h10 + 8'(i * 5)));
            send(8'h10 + 8'(i * 5), 1'b0, 1'b1);
            if (i == DEPTH - 1) check("t4_no_ovf_at_full", 32'(n_ovf - o0), 0);
        end
        check("t4_count_full", 32'(fifo_count), DEPTH);
        check("t4_ovf_pulse", 32'(n_ovf - o0), 1);
        check("t4_head_stable", 32'(rd_data), 32'h10);
        drain();

        // ---- prefix handling ----
`ifdef PS2_SCANCODE_DECODE_EN
        sb_q.push_back(10'h374);
        send(8'hE0, 1'b0, 1'b1);
        send(8'hF0, 1'b0, 1'b1);
        check("t5_prefix_not_pushed", 32'(fifo_count), 0);
        send(8'h74, 1'b0, 1'b1);
        check("t5_tagged_count", 32'(fifo_count), 1);
        check("t5_tagged_head", 32'(rd_data), 32'h374);
        sb_q.push_back(10'h01C);
        send(8'h1C, 1'b0, 1'b1);
        check("t5_untagged_count", 32'(fifo_count), 2);
`else
        sb_q.push_back(DATA_W'(8'hE0));
        sb_q.push_back(DATA_W'(8'hF0));
        send(8'hE0, 1'b0, 1'b1);
        send(8'hF0, 1'b0, 1'b1);
        check("t5_raw_count", 32'(fifo_count), 2);
        check("t5_raw_head", 32'(rd_data), 32'hE0);
`endif
        drain();

        // ---- rx_en abort ----
        p0 = n_par; f0 = n_frm; t0 = n_to; o0 = n_ovf;
        ps2_bits(mk_frame(8'h33, 1'b0, 1'b1), 4);
        check("t6_busy_before_abort", 32'(busy), 1);
        rx_en = 1'b0;
        tick(20);
        check("t6_aborted_idle", 32'(busy), 0);
        rx_en = 1'b1;
        tick(5);
        sb_q.push_back(DATA_W'(8'h55));
        send(8'h55, 1'b0, 1'b1);
        check("t6_count", 32'(fifo_count), 1);
        check("t6_no_errs", 32'((n_par - p0) + (n_frm - f0) + (n_to - t0) + (n_ovf - o0)), 0);
        drain();

        // ---- async reset mid-frame ----
        send(8'h11, 1'b0, 1'b1);
        ps2_bits(mk_frame(8'h22, 1'b0, 1'b1), 6);
        check("t7_pre_valid", 32'(rd_valid), 1);
        check("t7_pre_busy", 32'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t7_rst_valid", 32'(rd_valid), 0);
        check("t7_rst_count", 32'(fifo_count), 0);
        check("t7_rst_busy", 32'(busy), 0);
        check("t7_rst_data", 32'(rd_data), 0);
        check("t7_rst_errs", 32'({err_parity, err_frame, err_timeout, err_overflow}), 0);
        sb_q.delete();
        tick(3);
        reset_n = 1'b1;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
